// File: rtl/multdiv_iter_if.sv
// -----------------------------------------------------------------------------
// multdiv_iter_if
// Request/result bundle for the iterative multiply/divide unit.
//
// Signals (WIDTH = operand width):
//   start      requester -> unit   request strobe, sampled on the rising edge
//   ALU_OP     requester -> unit   5-bit op code (mult/multu/div/divu)
//   ALU_A      requester -> unit   multiplicand / dividend
//   ALU_B      requester -> unit   multiplier / divisor
//   ALU_HI     unit -> requester   product high half / remainder
//   ALU_LO     unit -> requester   product low half / quotient
//   MULTBUSY   unit -> requester   multiply in progress
//   DIVBUSY    unit -> requester   divide in progress
//   MULTWRITE  unit -> requester   one-cycle pulse, multiply result on HI/LO
//   DIVWRITE   unit -> requester   one-cycle pulse, divide result on HI/LO
//   DIV0       unit -> requester   divisor was zero (only meaningful with DIVWRITE)
//
// Modports: master = requester side, slave = the multiply/divide unit.
// -----------------------------------------------------------------------------
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       ALU_OP;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [WIDTH-1:0] ALU_HI;
  logic [WIDTH-1:0] ALU_LO;
  logic             MULTBUSY;
  logic             DIVBUSY;
  logic             MULTWRITE;
  logic             DIVWRITE;
  logic             DIV0;

  modport master (
    output start, ALU_OP, ALU_A, ALU_B,
    input  ALU_HI, ALU_LO, MULTBUSY, DIVBUSY, MULTWRITE, DIVWRITE, DIV0
  );

  modport slave (
    input  start, ALU_OP, ALU_A, ALU_B,
    output ALU_HI, ALU_LO, MULTBUSY, DIVBUSY, MULTWRITE, DIVWRITE, DIV0
  );
endinterface

// File: rtl/multdiv_iter.sv
// -----------------------------------------------------------------------------
// multdiv_iter
// Iterative signed/unsigned multiply and divide for the HI/LO path. One result
// bit per cycle: shift-add multiply and restoring divide over operand
// magnitudes, followed by a single sign-fix cycle and a one-cycle write pulse.
// Fixed latency: busy for WIDTH+1 cycles, then MULTWRITE/DIVWRITE for one.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset; aborts any operation in flight
//   bus   multdiv_iter_if.slave (start/op/operands in, HI/LO/busy/write/DIV0 out)
//
// Op codes: 01101 mult, 01110 multu, 01111 div, 10000 divu; anything else is
// ignored. Divide by zero returns LO = all ones, HI = dividend as sampled,
// DIV0 = 1. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  multdiv_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_MULT  = 5'b01101;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_raw_q;     // dividend exactly as sampled (div-by-zero HI)
  logic [WIDTH-1:0]   mag_a_q;     // |A| (multiplicand for MUL)
  logic [WIDTH-1:0]   mag_b_q;     // |B| (divisor for DIV; zero means div-by-zero)
  logic [2*WIDTH-1:0] acc_q;       // MUL: {partial, multiplier}; DIV: {rem, dividend/quotient}
  logic               is_div_q;
  logic               neg_res_q;   // operand signs differ on a signed op
  logic               neg_rem_q;   // signed op with negative dividend
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               multbusy_q;
  logic               divbusy_q;
  logic               multwrite_q;
  logic               divwrite_q;
  logic               div0_q;

  // ---------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             op_valid_d;
  logic             op_div_d;
  logic             op_signed_d;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;

  always_comb begin
    op_valid_d  = 1'b1;
    op_div_d    = 1'b0;
    op_signed_d = 1'b0;
    case (bus.ALU_OP)
      OP_MULT: begin
        op_signed_d = 1'b1;
      end
      OP_MULTU: begin
        op_signed_d = 1'b0;
      end
      OP_DIV: begin
        op_div_d    = 1'b1;
        op_signed_d = 1'b1;
      end
      OP_DIVU: begin
        op_div_d    = 1'b1;
      end
      default: begin
        op_valid_d  = 1'b0;
      end
    endcase

    a_neg_d = op_signed_d & bus.ALU_A[WIDTH-1];
    b_neg_d = op_signed_d & bus.ALU_B[WIDTH-1];
    // Negating MIN wraps to the same bit pattern, which read as unsigned is
    // exactly 2^(WIDTH-1): the correct magnitude.
    mag_a_d = a_neg_d ? (~bus.ALU_A + 1'b1) : bus.ALU_A;
    mag_b_d = b_neg_d ? (~bus.ALU_B + 1'b1) : bus.ALU_B;
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath and sign fix-up
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_trial_d;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;
  logic               fix_div0_d;

  always_comb begin
    // Shift-add: the low half holds the not-yet-consumed multiplier bits; the
    // carry out of the add becomes the new top bit after the right shift.
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH + 1){1'b0}});
    mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};

    // Restoring divide: trial-subtract the divisor from {rem, next dividend bit}.
    // A borrow means the shifted remainder stays and the quotient bit is 0.
    div_trial_d = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_q};
    div_acc_d   = div_trial_d[WIDTH] ?
                  {acc_q[2*WIDTH-2:0], 1'b0} :
                  {div_trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_d = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_d  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_d  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    fix_div0_d = is_div_q && (mag_b_q == {WIDTH{1'b0}});
    fix_hi_d   = prod_d[2*WIDTH-1:WIDTH];
    fix_lo_d   = prod_d[WIDTH-1:0];
    if (is_div_q) begin
      if (fix_div0_d) begin
        fix_hi_d = a_raw_q;
        fix_lo_d = {WIDTH{1'b1}};
      end else begin
        // MIN / -1 needs no special case: |MIN| / 1 = 2^(WIDTH-1) with equal
        // signs, so the quotient is the MIN bit pattern and the remainder 0.
        fix_hi_d = rem_d;
        fix_lo_d = quo_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_raw_q     <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      multbusy_q  <= 1'b0;
      divbusy_q   <= 1'b0;
      multwrite_q <= 1'b0;
      divwrite_q  <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      // Write pulses and DIV0 only live for the DONE cycle.
      multwrite_q <= 1'b0;
      divwrite_q  <= 1'b0;
      div0_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.start && op_valid_d) begin
            a_raw_q    <= bus.ALU_A;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            is_div_q   <= op_div_d;
            neg_res_q  <= a_neg_d ^ b_neg_d;
            neg_rem_q  <= a_neg_d;
            cnt_q      <= CNT_W'(WIDTH);
            acc_q      <= op_div_d ? {{WIDTH{1'b0}}, mag_a_d} : {{WIDTH{1'b0}}, mag_b_d};
            multbusy_q <= ~op_div_d;
            divbusy_q  <= op_div_d;
            state_q    <= op_div_d ? S_DIV : S_MUL;
          end
        end

        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_FIX;
          end
        end

        S_DIV: begin
          acc_q <= div_acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          hi_q        <= fix_hi_d;
          lo_q        <= fix_lo_d;
          div0_q      <= fix_div0_d;
          multwrite_q <= ~is_div_q;
          divwrite_q  <= is_div_q;
          multbusy_q  <= 1'b0;
          divbusy_q   <= 1'b0;
          state_q     <= S_DONE;
        end

        S_DONE: begin
          // start is deliberately not sampled here.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ALU_HI    = hi_q;
  assign bus.ALU_LO    = lo_q;
  assign bus.MULTBUSY  = multbusy_q;
  assign bus.DIVBUSY   = divbusy_q;
  assign bus.MULTWRITE = multwrite_q;
  assign bus.DIVWRITE  = divwrite_q;
  assign bus.DIV0      = div0_q;

endmodule
